// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU commit-trace monitor: run-state encodings
// and the layout of one trace record {cycle, pc, inst, alu_out, zero}.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_DONE    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_t;

  // Total record width for a given datapath and counter width.
  function automatic int rec_w(input int xlen, input int cnt_w);
    return cnt_w + 3 * xlen + 1;
  endfunction

  // Bit offsets (LSB position) of each record field.
  function automatic int off_zero();
    return 0;
  endfunction

  function automatic int off_alu();
    return 1;
  endfunction

  function automatic int off_inst(input int xlen);
    return 1 + xlen;
  endfunction

  function automatic int off_pc(input int xlen);
    return 1 + 2 * xlen;
  endfunction

  function automatic int off_cycle(input int xlen);
    return 1 + 3 * xlen;
  endfunction

  // Record width for the default 32-bit core with 16-bit counters.
  localparam int REC_W = rec_w(32, 16);

endpackage

// File: rtl/cpu_trace_monitor_fifo.sv
// trace_fifo: first-word fall-through FIFO holding trace records.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// both flags are registered from the next-pointer values.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem [DEPTH];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_q[AW-1:0]];

  // Next pointer values; flush returns both pointers to the origin.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  // Pointer and status-flag registers.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      empty <= (wr_d == rd_d);
      full  <= (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
    end
  end

  // Record storage; data is not reset.
  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: run controller and commit-trace capture for the
// single-cycle CPU. Captures one record per RUN cycle, ends the run on a
// PC self-loop (DONE) or a cycle budget (TIMEOUT), and drains records over
// a valid/ready port. Optional ALU signature: define CPU_TRACE_SIGNATURE_EN.
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 16,
  parameter int MAX_CYCLES  = 15,
  parameter int HALT_CYCLES = 3
) (
  input  logic                             CLK,
  input  logic                             rst,
  input  logic                             start,
  input  logic [XLEN-1:0]                  pc,
  input  logic [XLEN-1:0]                  inst,
  input  logic [XLEN-1:0]                  alu_out,
  input  logic                             zero,
  output logic                             trace_valid,
  input  logic                             trace_ready,
  output logic [rec_w(XLEN, CNT_W)-1:0]    trace_data,
  output logic [1:0]                       state,
  output logic [CNT_W-1:0]                 cycle_cnt,
  output logic                             overflow,
  output logic [CNT_W-1:0]                 drop_cnt,
  output logic [XLEN-1:0]                  sig
);

  localparam int RW = rec_w(XLEN, CNT_W);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   prev_pc_q;
  logic [CNT_W-1:0]  stable_q;
  logic              first_q;
  logic              run, start_ok, pop, push, drop;
  logic              halt_hit, timeout_hit;
  logic              fifo_full, fifo_empty;
  logic [RW-1:0]     rec;

  assign run         = (state_q == ST_RUN);
  assign start_ok    = start && !run;
  assign pop         = trace_valid && trace_ready;
  // A full FIFO still accepts a record when the head leaves the same cycle.
  assign push        = run && (!fifo_full || pop);
  assign drop        = run && fifo_full && !pop;
  assign rec         = {cycle_cnt, pc, inst, alu_out, zero};
  assign halt_hit    = run && !first_q && (pc == prev_pc_q) &&
                       (stable_q == CNT_W'(HALT_CYCLES - 1));
  assign timeout_hit = run && (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign trace_valid = !fifo_empty;
  assign state       = state_q;

  trace_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .rst   (rst),
    .flush (start_ok),
    .push  (push),
    .pop   (pop),
    .din   (rec),
    .dout  (trace_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Run-state register.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next run state; halt takes priority over timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    if (start_ok)         state_d = ST_RUN;
    else if (halt_hit)    state_d = ST_DONE;
    else if (timeout_hit) state_d = ST_TIMEOUT;
  end

  // Cycle/drop counters and PC self-loop tracking.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      prev_pc_q <= '0;
      stable_q  <= '0;
      first_q   <= 1'b0;
    end else if (start_ok) begin
      cycle_cnt <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      stable_q  <= '0;
      first_q   <= 1'b1;
    end else if (run) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
      end
      first_q   <= 1'b0;
      prev_pc_q <= pc;
      if (first_q)               stable_q <= '0;
      else if (pc == prev_pc_q)  stable_q <= stable_q + CNT_W'(1);
      else                       stable_q <= '0;
    end
  end

`ifdef CPU_TRACE_SIGNATURE_EN
  // Rotate-and-xor signature of every ALU result seen during RUN.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst)          sig <= '0;
    else if (start_ok) sig <= '0;
    else if (run)      sig <= {sig[XLEN-2:0], sig[XLEN-1]} ^ alu_out;
  end
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: a reference model predicts the
// records that must emerge and the status outputs; a monitor compares them.
module tb_cpu_trace_monitor;

  localparam int XLEN = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 16;
  localparam int MAXC = 20;
  localparam int HALTC = 3;
  localparam int RW = CNT_W + 3 * XLEN + 1;

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_TO = 2'd3;

  logic CLK, rst, start, zero, trace_valid, trace_ready, overflow;
  logic [XLEN-1:0] pc, inst, alu_out, sig;
  logic [RW-1:0] trace_data;
  logic [1:0] state;
  logic [CNT_W-1:0] cycle_cnt, drop_cnt;

  cpu_trace_monitor #(
    .XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W),
    .MAX_CYCLES(MAXC), .HALT_CYCLES(HALTC)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start), .pc(pc), .inst(inst),
    .alu_out(alu_out), .zero(zero), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data), .state(state),
    .cycle_cnt(cycle_cnt), .overflow(overflow), .drop_cnt(drop_cnt), .sig(sig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  logic [RW-1:0] last_rec;

  // Reference model state
  logic [RW-1:0]    exp_q[$];
  logic [XLEN-1:0]  pcs[$];
  logic [1:0]       m_state;
  logic [CNT_W-1:0] m_cyc, m_drop;
  logic             m_ovf;
  logic [XLEN-1:0]  m_sig;
  int               m_occ;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_cyc = '0; m_drop = '0; m_ovf = 1'b0; m_sig = '0;
    m_occ = 0; exp_q.delete(); pcs.delete();
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    logic pop_m, halted;
    logic [RW-1:0] r;
    if (!rst) begin
      model_reset();
      return;
    end
    pop_m = (m_occ > 0) && trace_ready;
    if (m_state != S_RUN) begin
      if (start) begin
        m_state = S_RUN; m_cyc = '0; m_drop = '0; m_ovf = 1'b0; m_sig = '0;
        m_occ = 0; exp_q.delete(); pcs.delete();
      end else if (pop_m) begin
        m_occ--;
      end
    end else begin
      r = {m_cyc, pc, inst, alu_out, zero};
      if (m_occ < DEPTH || pop_m) begin
        exp_q.push_back(r);
        if (!pop_m) m_occ++;
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
`ifdef CPU_TRACE_SIGNATURE_EN
      m_sig = {m_sig[XLEN-2:0], m_sig[XLEN-1]} ^ alu_out;
`endif
      pcs.push_back(pc);
      if (pcs.size() > HALTC + 1) void'(pcs.pop_front());
      // Halt: the last HALTC+1 PCs of this run are all identical.
      halted = (pcs.size() == HALTC + 1);
      foreach (pcs[i]) if (pcs[i] != pcs[0]) halted = 1'b0;
      if (halted) m_state = S_DONE;
      else if (m_cyc == 16'(MAXC - 1)) m_state = S_TO;
      m_cyc = m_cyc + 16'd1;
    end
  endtask

  always @(negedge CLK) begin
    #2;
    model_step();
  end

  // Monitor: compares the head record on each handshake and the status outputs.
  always @(negedge CLK) begin
    chk("trace_valid", 256'(trace_valid), 256'(exp_q.size() != 0));
    if (trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL trace_unexpected actual=%0h required=none", trace_data);
      end else begin
        chk("trace_data", 256'(trace_data), 256'(exp_q.pop_front()));
        last_rec = trace_data;
        pops++;
      end
    end
    chk("state", 256'(state), 256'(m_state));
    chk("cycle_cnt", 256'(cycle_cnt), 256'(m_cyc));
    chk("overflow", 256'(overflow), 256'(m_ovf));
    chk("drop_cnt", 256'(drop_cnt), 256'(m_drop));
    chk("sig", 256'(sig), 256'(m_sig));
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic arm();
    pops = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic drive(input logic [XLEN-1:0] p, input logic [XLEN-1:0] a);
    pc = p; inst = $urandom; alu_out = a; zero = (a == '0);
    cyc();
  endtask

  task automatic drain(input int expect_pops);
    int n;
    trace_ready = 1'b1;
    n = 0;
    while (trace_valid && n < 40) begin
      cyc();
      n++;
    end
    chk("drain_valid", 256'(trace_valid), 256'(0));
    chk("drain_pops", 256'(pops), 256'(expect_pops));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] exp_sig;
    rst = 1'b0; start = 1'b0; pc = '0; inst = '0; alu_out = '0; zero = 1'b0;
    trace_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_state", 256'(state), 256'(S_IDLE));
    chk("rst_valid", 256'(trace_valid), 256'(0));
    chk("rst_cycle", 256'(cycle_cnt), 256'(0));
    chk("rst_ovf", 256'(overflow), 256'(0));
    chk("rst_drop", 256'(drop_cnt), 256'(0));
    chk("rst_sig", 256'(sig), 256'(0));
    rst = 1'b1;
    cyc();

    // Counting run to timeout
    trace_ready = 1'b1;
    arm();
    for (int k = 0; k < 25; k++) drive(XLEN'(4 * k), $urandom);
    chk("cnt_state", 256'(state), 256'(S_TO));
    chk("cnt_cycle", 256'(cycle_cnt), 256'(MAXC));
    chk("cnt_ovf", 256'(overflow), 256'(0));
    chk("cnt_pops", 256'(pops), 256'(MAXC));

    // Halt on PC self-loop
    arm();
    for (int k = 0; k < 10; k++) drive((k < 2) ? XLEN'(4 * k) : XLEN'(8), $urandom);
    chk("halt_state", 256'(state), 256'(S_DONE));
    chk("halt_cycle", 256'(cycle_cnt), 256'(6));
    chk("halt_pops", 256'(pops), 256'(6));
    chk("halt_last_cycle", 256'(last_rec[RW-1 -: CNT_W]), 256'(5));
    chk("halt_last_pc", 256'(last_rec[RW-1-CNT_W -: XLEN]), 256'(8));

    // Overflow with the consumer stalled, then drain in order
    trace_ready = 1'b0;
    arm();
    for (int k = 0; k < 24; k++) drive(XLEN'(4 * k), $urandom);
    chk("ovf_state", 256'(state), 256'(S_TO));
    chk("ovf_flag", 256'(overflow), 256'(1));
    chk("ovf_drop", 256'(drop_cnt), 256'(MAXC - DEPTH));
    chk("ovf_valid", 256'(trace_valid), 256'(1));
    drain(DEPTH);

    // Full FIFO with a simultaneous pop accepts the record
    trace_ready = 1'b0;
    arm();
    for (int k = 0; k < 22; k++) begin
      trace_ready = (k >= 17);
      drive(XLEN'(4 * k), $urandom);
    end
    chk("fullpop_drop", 256'(drop_cnt), 256'(1));
    chk("fullpop_ovf", 256'(overflow), 256'(1));
    drain(DEPTH + 3);

    // Start ignored in RUN, then asynchronous reset mid-run
    trace_ready = 1'b1;
    arm();
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      drive(XLEN'(4 * k), $urandom);
    end
    start = 1'b0;
    chk("restart_ignored", 256'(cycle_cnt), 256'(5));
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_state", 256'(state), 256'(S_IDLE));
    chk("arst_valid", 256'(trace_valid), 256'(0));
    chk("arst_cycle", 256'(cycle_cnt), 256'(0));
    cyc();
    cyc();
    rst = 1'b1;
    cyc();

    // Signature over a short halting run
    arm();
    drive(0, 1); drive(0, 2); drive(0, 3); drive(0, 0);
    drive(0, $urandom); drive(0, $urandom);
`ifdef CPU_TRACE_SIGNATURE_EN
    exp_sig = 32'h6;
`else
    exp_sig = 32'h0;
`endif
    chk("sig_state", 256'(state), 256'(S_DONE));
    chk("sig_value", 256'(sig), 256'(exp_sig));

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      start = ($urandom_range(0, 15) == 0);
      trace_ready = $urandom_range(0, 1);
      drive(XLEN'(4 * $urandom_range(0, 2)), $urandom);
    end
    start = 1'b0;
    drain(pops + int'(exp_q.size()));

    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
